// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for the A/B/C general registers: one accepted write per cycle.
// Optional per-register write counters are enabled with REG_WRITE_ARB_STATS_EN.
module reg_write_arbiter #(
  parameter int WORD_SIZE = 19,
  parameter int NUM_REQ   = 3,
  parameter int GNT_W     = $clog2(NUM_REQ)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NUM_REQ-1:0]           REQ_VALID,
  input  logic [2*NUM_REQ-1:0]         REQ_SEL,
  input  logic [WORD_SIZE*NUM_REQ-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]           REQ_READY,
  input  logic                         HOLD,
  output logic                         LOAD_A,
  output logic                         LOAD_B,
  output logic                         LOAD_C,
  output logic [WORD_SIZE-1:0]         WR_DATA,
  output logic [GNT_W-1:0]             GNT_ID,
  output logic                         ERR_BAD_SEL
`ifdef REG_WRITE_ARB_STATS_EN
  ,
  output logic [15:0]                  WR_CNT_A,
  output logic [15:0]                  WR_CNT_B,
  output logic [15:0]                  WR_CNT_C
`endif
);

  typedef enum logic [1:0] {
    TGT_A   = 2'd0,
    TGT_B   = 2'd1,
    TGT_C   = 2'd2,
    TGT_BAD = 2'd3
  } tgt_e;

  logic [GNT_W-1:0]     last;
  logic                 found;
  logic [GNT_W-1:0]     win;
  tgt_e                 win_tgt;
  logic [WORD_SIZE-1:0] win_data;
  logic [NUM_REQ-1:0]   ready;
  int unsigned          idx;

  // Scan starts one past the last winner; the first valid requester wins.
  always_comb begin
    ready    = '0;
    found    = 1'b0;
    win      = '0;
    win_tgt  = TGT_A;
    win_data = '0;
    idx      = 0;
    if (RST_N && !HOLD) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = (32'(last) + k) % NUM_REQ;
        if (!found && REQ_VALID[idx]) begin
          found      = 1'b1;
          ready[idx] = 1'b1;
          win        = GNT_W'(idx);
          win_tgt    = tgt_e'(REQ_SEL[2*idx +: 2]);
          win_data   = REQ_DATA[WORD_SIZE*idx +: WORD_SIZE];
        end
      end
    end
  end

  assign REQ_READY = ready;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      LOAD_A      <= 1'b0;
      LOAD_B      <= 1'b0;
      LOAD_C      <= 1'b0;
      WR_DATA     <= '0;
      GNT_ID      <= '0;
      ERR_BAD_SEL <= 1'b0;
      last        <= GNT_W'(NUM_REQ - 1);
    end else begin
      LOAD_A <= 1'b0;
      LOAD_B <= 1'b0;
      LOAD_C <= 1'b0;
      if (found) begin
        GNT_ID <= win;
        last   <= win;
        // An illegal target is still consumed so the requester never stalls.
        unique case (win_tgt)
          TGT_A: begin
            LOAD_A  <= 1'b1;
            WR_DATA <= win_data;
          end
          TGT_B: begin
            LOAD_B  <= 1'b1;
            WR_DATA <= win_data;
          end
          TGT_C: begin
            LOAD_C  <= 1'b1;
            WR_DATA <= win_data;
          end
          TGT_BAD: ERR_BAD_SEL <= 1'b1;
        endcase
      end
    end
  end

`ifdef REG_WRITE_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      WR_CNT_A <= '0;
      WR_CNT_B <= '0;
      WR_CNT_C <= '0;
    end else if (found) begin
      if (win_tgt == TGT_A && WR_CNT_A != '1) WR_CNT_A <= WR_CNT_A + 16'd1;
      if (win_tgt == TGT_B && WR_CNT_B != '1) WR_CNT_B <= WR_CNT_B + 16'd1;
      if (win_tgt == TGT_C && WR_CNT_C != '1) WR_CNT_C <= WR_CNT_C + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed scoreboard bench for reg_write_arbiter (default build, 3 requesters, 19-bit data).
module tb_reg_write_arbiter;

  localparam int W = 19;
  localparam int N = 3;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [N-1:0] REQ_VALID;
  logic [2*N-1:0] REQ_SEL;
  logic [W*N-1:0] REQ_DATA;
  logic [N-1:0] REQ_READY;
  logic         HOLD;
  logic         LOAD_A, LOAD_B, LOAD_C;
  logic [W-1:0] WR_DATA;
  logic [1:0]   GNT_ID;
  logic         ERR_BAD_SEL;

  reg_write_arbiter #(.WORD_SIZE(W), .NUM_REQ(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_SEL(REQ_SEL),
    .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .HOLD(HOLD),
    .LOAD_A(LOAD_A), .LOAD_B(LOAD_B), .LOAD_C(LOAD_C),
    .WR_DATA(WR_DATA), .GNT_ID(GNT_ID), .ERR_BAD_SEL(ERR_BAD_SEL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]   load;   // {C,B,A}
    logic [W-1:0] data;
    logic [1:0]   gnt;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] sel, input logic [W-1:0] data);
    REQ_SEL[2*i +: 2]  = sel;
    REQ_DATA[W*i +: W] = data;
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_load"}, {29'd0, LOAD_C, LOAD_B, LOAD_A}, {29'd0, e.load});
      check({tag, "_data"}, {13'd0, WR_DATA}, {13'd0, e.data});
      check({tag, "_gnt"},  {30'd0, GNT_ID}, {30'd0, e.gnt});
      check({tag, "_err"},  {31'd0, ERR_BAD_SEL}, {31'd0, e.err});
    end
  endtask

  // One cycle: inputs already driven; check READY, queue the expected registered result, pop after the edge.
  task automatic cyc(input string tag, input logic [2:0] exp_ready, input logic [2:0] exp_load,
                     input logic [W-1:0] exp_data, input logic [1:0] exp_gnt, input logic exp_err);
    #3;
    check({tag, "_ready"}, {29'd0, REQ_READY}, {29'd0, exp_ready});
    sb.push_back('{load: exp_load, data: exp_data, gnt: exp_gnt, err: exp_err});
    @(posedge CLK); #1;
    pop_and_check(tag);
  endtask

  initial begin
    RST_N = 1'b0; HOLD = 1'b0; REQ_VALID = '0; REQ_SEL = '0; REQ_DATA = '0;

    // Reset: READY suppressed even with all requesters valid
    REQ_VALID = 3'b111;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rst_ready", {29'd0, REQ_READY}, 32'd0);
    sb.push_back('{load: 3'b000, data: '0, gnt: 2'd0, err: 1'b0});
    pop_and_check("rst");
    RST_N = 1'b1;

    // Rotation: A/B/C targets, pointer starts so req0 wins first
    set_req(0, 2'd0, 19'h00001);
    set_req(1, 2'd1, 19'h00002);
    set_req(2, 2'd2, 19'h00003);
    for (int r = 0; r < 2; r++) begin
      cyc("rr0", 3'b001, 3'b001, 19'h00001, 2'd0, 1'b0);
      cyc("rr1", 3'b010, 3'b010, 19'h00002, 2'd1, 1'b0);
      cyc("rr2", 3'b100, 3'b100, 19'h00003, 2'd2, 1'b0);
    end
    REQ_VALID = 3'b000;
    cyc("rr_idle", 3'b000, 3'b000, 19'h00003, 2'd2, 1'b0);

    // Single request to B, then strobe must drop
    set_req(0, 2'd1, 19'h1A2B3);
    REQ_VALID = 3'b001;
    cyc("single", 3'b001, 3'b010, 19'h1A2B3, 2'd0, 1'b0);
    REQ_VALID = 3'b000;
    cyc("single_end", 3'b000, 3'b000, 19'h1A2B3, 2'd0, 1'b0);

    // Two sources targeting C are serialized
    set_req(1, 2'd2, 19'h11111);
    set_req(2, 2'd2, 19'h22222);
    REQ_VALID = 3'b110;
    cyc("samec1", 3'b010, 3'b100, 19'h11111, 2'd1, 1'b0);
    REQ_VALID = 3'b100;
    cyc("samec2", 3'b100, 3'b100, 19'h22222, 2'd2, 1'b0);
    REQ_VALID = 3'b000;
    cyc("samec_end", 3'b000, 3'b000, 19'h22222, 2'd2, 1'b0);

    // HOLD: accept req0, then stall; previously registered write still issues
    set_req(0, 2'd0, 19'h3ABCD);
    REQ_VALID = 3'b001;
    cyc("pre_hold", 3'b001, 3'b001, 19'h3ABCD, 2'd0, 1'b0);
    set_req(0, 2'd1, 19'h04444);
    set_req(1, 2'd2, 19'h11111);
    REQ_VALID = 3'b011;
    HOLD = 1'b1;
    check("hold_issue", {31'd0, LOAD_A}, 32'd1);
    for (int h = 0; h < 3; h++)
      cyc("hold", 3'b000, 3'b000, 19'h3ABCD, 2'd0, 1'b0);
    HOLD = 1'b0;
    cyc("post_hold1", 3'b010, 3'b100, 19'h11111, 2'd1, 1'b0);
    REQ_VALID = 3'b001;
    cyc("post_hold0", 3'b001, 3'b010, 19'h04444, 2'd0, 1'b0);
    REQ_VALID = 3'b000;
    cyc("post_hold_idle", 3'b000, 3'b000, 19'h04444, 2'd0, 1'b0);

    // Illegal target: accepted, no strobe, sticky error
    set_req(2, 2'd3, 19'h7FFFF);
    REQ_VALID = 3'b100;
    cyc("badsel", 3'b100, 3'b000, 19'h04444, 2'd2, 1'b1);
    REQ_VALID = 3'b000;
    cyc("badsel_idle", 3'b000, 3'b000, 19'h04444, 2'd2, 1'b1);
    set_req(1, 2'd0, 19'h12345);
    REQ_VALID = 3'b010;
    cyc("err_sticky", 3'b010, 3'b001, 19'h12345, 2'd1, 1'b1);

    // Reset mid-operation: req0 ready, reset lands before the transfer edge
    set_req(0, 2'd0, 19'h2AAAA);
    set_req(2, 2'd1, 19'h00001);
    REQ_VALID = 3'b001;
    #3;
    check("midrst_ready_pre", {29'd0, REQ_READY}, 32'd1);
    RST_N = 1'b0;
    #1;
    check("midrst_ready_low", {29'd0, REQ_READY}, 32'd0);
    sb.push_back('{load: 3'b000, data: '0, gnt: 2'd0, err: 1'b0});
    @(posedge CLK); #1;
    pop_and_check("midrst");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    REQ_VALID = 3'b101;
    cyc("after_rst0", 3'b001, 3'b001, 19'h2AAAA, 2'd0, 1'b0);
    REQ_VALID = 3'b100;
    cyc("after_rst2", 3'b100, 3'b010, 19'h00001, 2'd2, 1'b0);
    REQ_VALID = 3'b000;
    cyc("after_rst_idle", 3'b000, 3'b000, 19'h00001, 2'd2, 1'b0);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
